proc_control: RTL and testbench
===============================

# proc_control

Multicycle control unit that drives the datapath around the 16-bit ALU. It latches a 9-bit instruction from `DIN` and sequences register read/write enables, the A/G register loads and the 2-bit ALU operation code over one to three execute cycles. The ALU operation code it emits uses the same encoding the ALU consumes: `00` add, `01` sub, `10`/`11` zero. It sits between the top-level processor wrapper and the register file / A / G / bus-mux datapath.

## Interface
Parameters:
- `NREGS`, 8: number of general registers; fixed at 8 because register fields are 3 bits.

Ports. One clock; `Reset` is asynchronous and active-high.
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high; forces the idle state.
- `Run` in 1: start request, sampled in T0 only.
- `DIN` in 16: instruction word in T0; immediate operand in T1 for `mvi`.
- `GNotZero` in 1: G register != 0. Used only with `PROC_CONTROL_MVNZ_EN`.
- `Rin` out 8: one-hot register-file write enable.
- `Rout` out 8: one-hot register-file bus-drive enable.
- `Gout` out 1: G drives the bus.
- `DINout` out 1: `DIN` drives the bus.
- `Ain` out 1: load A from the bus.
- `Gin` out 1: load G from the ALU output.
- `Operacao` out 2: ALU operation code.
- `Done` out 1: final cycle of an instruction.

## Operation
- Instruction register `IR[8:0]` holds fields `III XXX YYY`: opcode, destination X, source Y.
- Opcodes:
  - `000` mv: Rx←Ry.
  - `001` mvi: Rx←DIN.
  - `010` add: Rx←Rx+Ry.
  - `011` sub: Rx←Rx−Ry.
  - `100` mvnz: conditional move (see Configuration).
  - `101`–`111`: illegal.
- State machine states: T0, T1, T2, T3.
  - T0: idle/fetch. If `Run`=1, load `IR`←`DIN[8:0]` and go to T1; otherwise stay in T0. All outputs are idle.
  - mv, T1: `Rout[Y]`, `Rin[X]`, `Done`; go to T0.
  - mvi, T1: `DINout`, `Rin[X]`, `Done`; go to T0.
  - add/sub, T1: `Rout[X]`, `Ain`; go to T2.
  - add/sub, T2: `Rout[Y]`, `Gin`, `Operacao`=`00` for add or `01` for sub; go to T3.
  - add/sub, T3: `Gout`, `Rin[X]`, `Done`; go to T0.
  - illegal, T1: `Done` only, with no enables; go to T0.
- Outputs are decoded combinationally from the state and `IR`.
- Idle output values: all enables 0, `Done`=0, `Operacao`=`10`. `Operacao` is a value other than `10` only in T2 of add/sub.
- At most one bus driver (`Rout` bit, `Gout`, `DINout`) is active in any cycle.
- `Rin` and `Rout` are each zero or one-hot.
- `Run` is ignored in T1–T3. An instruction always completes once started.
- X = Y is legal.
  - mv R3,R3 asserts `Rout[3]` and `Rin[3]` together.
  - add R2,R2 doubles R2.

## Timing
- Reset values: state = T0, `IR` = 0, outputs at the idle values above.
- Reset asserted mid-instruction aborts it immediately (asynchronously).
  - Outputs go idle in the same cycle.
  - No `Done` is issued for the aborted instruction.
- Latency from the `Run` sample edge to `Done` high:
  - mv, mvi, mvnz, illegal: 1 cycle.
  - add/sub: 3 cycles.
- `Done` is high for exactly one cycle.
- Back-to-back issue: `Run` held high is sampled in the T0 immediately after `Done`. Instruction throughput is therefore 2 or 4 cycles.
- For `mvi`, the immediate must be valid on `DIN` during T1, the cycle after the instruction word.

## Configuration
- `PROC_CONTROL_MVNZ_EN` defined:
  - Opcode `100` = mvnz.
  - T1: if `GNotZero`=1, assert `Rout[Y]` and `Rin[X]`. Always assert `Done`. Go to T0.
- Not defined:
  - Opcode `100` is illegal (`Done`-only, 1 cycle).
  - `GNotZero` is unused.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_MVNZ`);
  - state encoding T0–T3 (2 bits);
  - ALU codes `ULA_ADD`=`00`, `ULA_SUB`=`01`, `ULA_ZERO`=`10`.
  - The ALU and the datapath reuse these codes.
- Sub-module `dec3to8` is a 3-to-8 one-hot decoder with an enable input. It is instantiated twice, once for `Rin` and once for `Rout`.

## Test plan
- Reset, then `Run`=0 for 5 cycles → state T0, all outputs idle, `Operacao`=`10`, `Done` never high.
- `DIN`=`9'b001_010_000` with `Run`=1, then `DIN`=`16'h00A5` in T1 → T1 asserts `DINout`, `Rin`=`8'b00000100`, `Done`; the cycle after is T0.
- add R1,R2 (`DIN`=`9'b010_001_010`) → T1: `Rout`=`8'h02`, `Ain`. T2: `Rout`=`8'h04`, `Gin`, `Operacao`=`00`. T3: `Gout`, `Rin`=`8'h02`, `Done`.
- sub R1,R2 (`DIN`=`9'b011_001_010`) → identical to add except `Operacao`=`01` in T2.
- `Reset` pulsed during T2 of add → outputs idle in the same cycle; after reset release, `Run`=0 keeps T0 and no `Done` is seen.
- Opcode `100`, X=1, Y=3, `GNotZero`=0 then 1:
  - with the macro: T1 shows no enables, then `Rout`=`8'h08`/`Rin`=`8'h02`, with `Done` in both runs.
  - without the macro: `Done` only in both runs.
  - Opcode `111` gives `Done` only.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode, FSM state and ALU operation encodings for the processor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// The ALU and the datapath import the same ULA_* codes, so the control unit
// and the ALU cannot drift apart on the operation encoding.
package proc_pkg;

   localparam int NREGS_FIXED = 8;  // 3-bit register fields address 8 registers

   // Instruction register layout: III XXX YYY
   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;

   // ALU operation codes; both 10 and 11 make the ALU output zero
   localparam logic [1:0] ULA_ADD  = 2'b00;
   localparam logic [1:0] ULA_SUB  = 2'b01;
   localparam logic [1:0] ULA_ZERO = 2'b10;

   typedef enum logic [1:0] {
      T0 = 2'd0,   // idle / fetch
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   en   in  1 : decoder enable
//   sel  in  3 : index of the bit to set
//   y    out 8 : one-hot (or zero) result
module dec3to8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] y
);

   always_comb begin
      y = 8'b0;
      if (en) y[sel] = 1'b1;
   end

endmodule

// File: rtl/proc_control.sv
// proc_control: multicycle control FSM sequencing register file / A / G / bus-mux enables.
// Latency: Done 1 cycle after the Run sample for mv/mvi/mvnz/illegal, 3 cycles for add/sub.
// Backpressure: none; Run is only looked at in T0, a started instruction always completes.
//
// Optional feature: define PROC_CONTROL_MVNZ_EN to make opcode 100 a conditional
// move on GNotZero; otherwise opcode 100 is treated as illegal (Done only).
//
// Ports:
//   Clock    in  1      : rising-edge clock
//   Reset    in  1      : asynchronous active-high reset to T0
//   Run      in  1      : start request, sampled in T0
//   DIN      in  16     : instruction word in T0, immediate in T1 for mvi
//   GNotZero in  1      : G != 0, used only by mvnz
//   Rin      out NREGS  : one-hot register write enable
//   Rout     out NREGS  : one-hot register bus-drive enable
//   Gout     out 1      : G drives the bus
//   DINout   out 1      : DIN drives the bus
//   Ain      out 1      : load A from the bus
//   Gin      out 1      : load G from the ALU
//   Operacao out 2      : ALU operation code
//   Done     out 1      : last cycle of an instruction
module proc_control
   import proc_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Run,
   input  logic [15:0]      DIN,
   input  logic             GNotZero,
   output logic [NREGS-1:0] Rin,
   output logic [NREGS-1:0] Rout,
   output logic             Gout,
   output logic             DINout,
   output logic             Ain,
   output logic             Gin,
   output logic [1:0]       Operacao,
   output logic             Done
);

   state_t     state, state_nxt;
   logic [8:0] ir;

   logic [2:0] opcode, rx, ry;
   assign opcode = ir[8:6];
   assign rx     = ir[5:3];
   assign ry     = ir[2:0];

   logic       rin_en, rout_en;
   logic [2:0] rout_sel;

   // Only the low 9 bits of DIN form the instruction; the immediate goes to
   // the datapath directly. GNotZero is only consumed by the optional mvnz.
   logic unused_inputs;
   assign unused_inputs = ^{DIN[15:9], GNotZero};

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= T0;
         ir    <= 9'b0;
      end else begin
         state <= state_nxt;
         if (state == T0 && Run) ir <= DIN[8:0];
      end
   end

   always_comb begin
      state_nxt = state;
      rin_en    = 1'b0;
      rout_en   = 1'b0;
      rout_sel  = ry;
      Gout      = 1'b0;
      DINout    = 1'b0;
      Ain       = 1'b0;
      Gin       = 1'b0;
      Operacao  = ULA_ZERO;
      Done      = 1'b0;

      unique case (state)
         T0: begin
            if (Run) state_nxt = T1;
         end
         T1: begin
            state_nxt = T0;
            case (opcode)
               OP_MV: begin
                  rout_en = 1'b1;
                  rin_en  = 1'b1;
                  Done    = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  rin_en = 1'b1;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_sel  = rx;   // first operand goes into A
                  rout_en   = 1'b1;
                  Ain       = 1'b1;
                  state_nxt = T2;
               end
`ifdef PROC_CONTROL_MVNZ_EN
               OP_MVNZ: begin
                  rout_en = GNotZero;
                  rin_en  = GNotZero;
                  Done    = 1'b1;
               end
`endif
               default: begin
                  // illegal opcode: retire without touching the datapath
                  Done = 1'b1;
               end
            endcase
         end
         T2: begin
            // only add/sub reach T2
            rout_en   = 1'b1;
            Gin       = 1'b1;
            Operacao  = (opcode == OP_SUB) ? ULA_SUB : ULA_ADD;
            state_nxt = T3;
         end
         T3: begin
            Gout      = 1'b1;
            rin_en    = 1'b1;
            Done      = 1'b1;
            state_nxt = T0;
         end
         default: state_nxt = T0;
      endcase
   end

   // Rin always targets X; Rout targets X (T1 of add/sub) or Y.
   dec3to8 u_rin_dec (
      .en  (rin_en),
      .sel (rx),
      .y   (Rin)
   );

   dec3to8 u_rout_dec (
      .en  (rout_en),
      .sel (rout_sel),
      .y   (Rout)
   );

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;
   import proc_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Run = 1'b0;
   logic [15:0] DIN = 16'h0;
   logic        GNotZero = 1'b0;
   logic [7:0]  Rin, Rout;
   logic        Gout, DINout, Ain, Gin, Done;
   logic [1:0]  Operacao;

   int checks = 0;
   int errors = 0;

   // Scoreboard of expected output vectors, and matching per-cycle stimulus.
   logic [22:0] sb[$];
   logic        run_q[$];
   logic [15:0] din_q[$];
   logic        gnz_q[$];

   proc_control #(.NREGS(8)) dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .GNotZero(GNotZero),
      .Rin(Rin), .Rout(Rout), .Gout(Gout), .DINout(DINout), .Ain(Ain),
      .Gin(Gin), .Operacao(Operacao), .Done(Done)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   // {Rin, Rout, Gout, DINout, Ain, Gin, Operacao, Done}
   function automatic logic [22:0] ex(input logic [7:0] rin, input logic [7:0] rout,
                                      input logic gout, input logic dinout,
                                      input logic ain, input logic gin,
                                      input logic [1:0] op, input logic done);
      return {rin, rout, gout, dinout, ain, gin, op, done};
   endfunction

   function automatic logic [22:0] outs();
      return {Rin, Rout, Gout, DINout, Ain, Gin, Operacao, Done};
   endfunction

   localparam logic [22:0] IDLE = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};

   // Queue one cycle of stimulus together with the outputs expected in that cycle.
   task automatic push(input logic run, input logic [15:0] din, input logic gnz,
                       input logic [22:0] e);
      run_q.push_back(run);
      din_q.push_back(din);
      gnz_q.push_back(gnz);
      sb.push_back(e);
   endtask

   task automatic test_reset;
      logic [22:0] got, e;
      Reset = 1'b1;
      Run = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      got = outs();
      checks++;
      if (got !== IDLE) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", got, IDLE);
      end
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) push(1'b0, 16'h01FF, 1'b1, IDLE);
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", got, e);
         end
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_mvi;
      logic [22:0] got, e;
      push(1'b1, 16'h0050, 1'b0, IDLE);
      push(1'b0, 16'h00A5, 1'b0, ex(8'h04, 8'h00, 0, 1, 0, 0, 2'b10, 1));
      push(1'b0, 16'h0000, 1'b0, IDLE);
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mvi: got %h expected %h", got, e);
         end
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_alu(input logic is_sub);
      logic [22:0] got, e;
      push(1'b1, is_sub ? 16'h00CA : 16'h008A, 1'b0, IDLE);
      push(1'b0, 16'h0000, 1'b0, ex(8'h00, 8'h02, 0, 0, 1, 0, 2'b10, 0));
      push(1'b0, 16'h0000, 1'b0, ex(8'h00, 8'h04, 0, 0, 0, 1, is_sub ? 2'b01 : 2'b00, 0));
      push(1'b0, 16'h0000, 1'b0, ex(8'h02, 8'h00, 1, 0, 0, 0, 2'b10, 1));
      push(1'b0, 16'h0000, 1'b0, IDLE);
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", is_sub ? "sub" : "add", got, e);
         end
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_reset_abort;
      logic [22:0] got, e;
      push(1'b1, 16'h008A, 1'b0, IDLE);
      push(1'b0, 16'h0000, 1'b0, ex(8'h00, 8'h02, 0, 0, 1, 0, 2'b10, 0));
      push(1'b0, 16'h0000, 1'b0, ex(8'h00, 8'h04, 0, 0, 0, 1, 2'b00, 0));
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL abort_pre: got %h expected %h", got, e);
         end
         if (sb.size() > 0) begin
            @(posedge Clock); #1;
         end
      end
      // mid-T2: asynchronous reset must idle the outputs immediately
      #1 Reset = 1'b1;
      #1;
      got = outs();
      checks++;
      if (got !== IDLE) begin
         errors++;
         $display("FAIL abort_async: got %h expected %h", got, IDLE);
      end
      @(negedge Clock);
      Reset = 1'b0;
      @(posedge Clock); #1;
      for (int i = 0; i < 4; i++) push(1'b0, 16'h0000, 1'b0, IDLE);
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL abort_post: got %h expected %h", got, e);
         end
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_mvnz_illegal;
      logic [22:0] got, e, done_only;
      done_only = ex(8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 1);
      // mvnz R1,R3 = 100_001_011
      push(1'b1, 16'h010B, 1'b0, IDLE);
      push(1'b0, 16'h0000, 1'b0, done_only);
      push(1'b1, 16'h010B, 1'b1, IDLE);
`ifdef PROC_CONTROL_MVNZ_EN
      push(1'b0, 16'h0000, 1'b1, ex(8'h02, 8'h08, 0, 0, 0, 0, 2'b10, 1));
`else
      push(1'b0, 16'h0000, 1'b1, done_only);
`endif
      // opcode 111, X=2, Y=5
      push(1'b1, 16'h01D5, 1'b1, IDLE);
      push(1'b0, 16'h0000, 1'b1, done_only);
      push(1'b0, 16'h0000, 1'b0, IDLE);
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mvnz_illegal: got %h expected %h", got, e);
         end
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [22:0] got, e;
      // add R2,R2 with Run held high and DIN garbage during T1..T3
      push(1'b1, 16'h0092, 1'b0, IDLE);
      push(1'b1, 16'hFFFF, 1'b0, ex(8'h00, 8'h04, 0, 0, 1, 0, 2'b10, 0));
      push(1'b1, 16'hFFFF, 1'b0, ex(8'h00, 8'h04, 0, 0, 0, 1, 2'b00, 0));
      push(1'b1, 16'hFFFF, 1'b0, ex(8'h04, 8'h00, 1, 0, 0, 0, 2'b10, 1));
      // mv R3,R3
      push(1'b1, 16'h001B, 1'b0, IDLE);
      push(1'b1, 16'h01FF, 1'b0, ex(8'h08, 8'h08, 0, 0, 0, 0, 2'b10, 1));
      // mvi R7, imm
      push(1'b1, 16'h0078, 1'b0, IDLE);
      push(1'b1, 16'h1234, 1'b0, ex(8'h80, 8'h00, 0, 1, 0, 0, 2'b10, 1));
      push(1'b0, 16'h0000, 1'b0, IDLE);
      push(1'b0, 16'h0000, 1'b0, IDLE);
      while (sb.size() > 0) begin
         Run = run_q.pop_front(); DIN = din_q.pop_front(); GNotZero = gnz_q.pop_front();
         #1;
         got = outs();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL back_to_back: got %h expected %h", got, e);
         end
         @(posedge Clock); #1;
      end
   endtask

   initial begin
      test_reset();
      test_mvi();
      test_alu(1'b0);
      test_alu(1'b1);
      test_reset_abort();
      test_mvnz_illegal();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
